// File: rtl/myproject_mul_pkg.sv
// Shared constants and helpers for the pipelined multi-lane multiplier.
package myproject_mul_pkg;

    localparam int MUL_MAX_STAGE = 8;

    function automatic int MUL_PROD_W(input int w0, input int w1);
        return w0 + w1;
    endfunction

    // Signed bounds of a w-bit two's-complement result.
    function automatic longint mul_sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint mul_sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/myproject_mul_pipe_lane.sv
// One multiplier lane: unsigned x signed multiply, NUM_STAGE data registers,
// wrap or (with MYPROJECT_MUL_SAT_EN) saturating narrowing into the final stage.
module myproject_mul_pipe_lane
    import myproject_mul_pkg::*;
#(
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 17,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [din0_WIDTH-1:0] a_i,
    input  logic [din1_WIDTH-1:0] b_i,
`ifdef MYPROJECT_MUL_SAT_EN
    output logic                  sat_o,
`endif
    output logic [dout_WIDTH-1:0] y_o
);
    localparam int PW = MUL_PROD_W(din0_WIDTH, din1_WIDTH);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] nar_src;

    // PW bits hold the full product exactly, so no precision is lost here.
    assign a_ext = PW'($signed({1'b0, a_i}));
    assign b_ext = PW'($signed(b_i));
    assign prod  = a_ext * b_ext;

    if (NUM_STAGE == 1) begin : g_one
        assign nar_src = prod;
    end else begin : g_multi
        logic signed [PW-1:0] p_q [NUM_STAGE-1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < NUM_STAGE - 1; i++) p_q[i] <= '0;
            end else if (en_i) begin
                p_q[0] <= prod;
                for (int i = 1; i < NUM_STAGE - 1; i++) p_q[i] <= p_q[i-1];
            end
        end

        assign nar_src = p_q[NUM_STAGE-2];
    end

    logic [dout_WIDTH-1:0] y_d;
    logic [dout_WIDTH-1:0] y_q;

`ifdef MYPROJECT_MUL_SAT_EN
    logic   sat_d;
    logic   sat_q;
    longint p64;

    always_comb begin
        p64   = longint'(nar_src);
        y_d   = dout_WIDTH'(nar_src);
        sat_d = 1'b0;
        if (p64 > mul_sat_max(dout_WIDTH)) begin
            y_d   = dout_WIDTH'(mul_sat_max(dout_WIDTH));
            sat_d = 1'b1;
        end else if (p64 < mul_sat_min(dout_WIDTH)) begin
            y_d   = dout_WIDTH'(mul_sat_min(dout_WIDTH));
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)     sat_q <= 1'b0;
        else if (en_i) sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`else
    assign y_d = dout_WIDTH'(nar_src);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)     y_q <= '0;
        else if (en_i) y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined multi-lane multiplier with valid/ready flow control.
// Optional saturation and dout_sat port with MYPROJECT_MUL_SAT_EN.
module myproject_mul_pipe
    import myproject_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int LANES      = 4,
    parameter int din0_WIDTH = 17,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 26
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*din0_WIDTH-1:0] din0,
    input  logic [LANES*din1_WIDTH-1:0] din1,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef MYPROJECT_MUL_SAT_EN
    output logic [LANES-1:0]            dout_sat,
`endif
    output logic [LANES*dout_WIDTH-1:0] dout
);
    if (NUM_STAGE < 1 || NUM_STAGE > MUL_MAX_STAGE ||
        dout_WIDTH > MUL_PROD_W(din0_WIDTH, din1_WIDTH)) begin : g_bad_cfg
        $error("myproject_mul_pipe: illegal NUM_STAGE or dout_WIDTH");
    end

    logic                 adv;
    logic [NUM_STAGE-1:0] v_q;
    logic [NUM_STAGE-1:0] v_d;

    // One global enable: the whole pipe either shifts or freezes.
    assign adv       = !v_q[NUM_STAGE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NUM_STAGE-1];

    always_comb begin
        v_d = v_q;
        if (adv) begin
            v_d[0] = in_valid;
            for (int i = 1; i < NUM_STAGE; i++) v_d[i] = v_q[i-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) v_q <= '0;
        else        v_q <= v_d;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        myproject_mul_pipe_lane #(
            .NUM_STAGE (NUM_STAGE),
            .din0_WIDTH(din0_WIDTH),
            .din1_WIDTH(din1_WIDTH),
            .dout_WIDTH(dout_WIDTH)
        ) u_lane (
            .clk_i(ap_clk),
            .rst_i(ap_rst),
            .en_i (adv),
            .a_i  (din0[g*din0_WIDTH +: din0_WIDTH]),
            .b_i  (din1[g*din1_WIDTH +: din1_WIDTH]),
`ifdef MYPROJECT_MUL_SAT_EN
            .sat_o(dout_sat[g]),
`endif
            .y_o  (dout[g*dout_WIDTH +: dout_WIDTH])
        );
    end

endmodule
